// File: rtl/cpu_pkg.sv
// Shared CPU type definitions: datapath typedefs, condition codes,
// sequencer state encoding and the interrupt vector helper.
package cpu_pkg;

   typedef logic [7:0]  opcode_t;
   typedef logic [7:0]  reg8_t;
   typedef logic [15:0] reg16_t;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC,
      ALU_AND, ALU_XOR, ALU_OR,  ALU_CP,
      ALU_INC, ALU_DEC, ALU_NOP
   } alu_op_t;

   typedef enum logic [1:0] {
      IDU_NONE, IDU_INC, IDU_DEC
   } idu_mode_t;

   typedef struct packed {
      logic       en;
      logic [1:0] sel;
   } s_rr_wb_t;

   typedef struct packed {
      reg8_t a;
      reg8_t f;
   } s_acc_t;

   typedef struct packed {
      reg8_t hi;
      reg8_t lo;
   } s_arg_t;

   // Branch condition selected by opcode[4:3]
   typedef enum logic [1:0] {
      CC_NZ, CC_Z, CC_NC, CC_C
   } cc_t;

   // Sequencer mode; cb_mode/int_mode/halted are decoded from this
   typedef enum logic [1:0] {
      ST_EXEC, ST_EXEC_CB, ST_INT, ST_HALT
   } seq_state_t;

   localparam opcode_t OPC_CB = 8'hCB;

   // Dispatch address of source idx, wrapping to 8 bits
   function automatic reg8_t irq_vector(input reg8_t base, input int unsigned idx,
                                        input int unsigned stride);
      int unsigned full;
      full = {24'd0, base} + idx * stride;
      return full[7:0];
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Decoder/flag/interrupt bundle between the sequencer and the rest of the CPU.
interface control_sequencer_if #(
   parameter int STEP_W  = 3,
   parameter int NUM_IRQ = 5
);
   logic [7:0]         db_in;
   logic               dec_done;
   logic               dec_is_cond;
   logic [STEP_W-1:0]  dec_next_cond;
   logic               dec_halt;
   logic               dec_ei;
   logic               dec_di;
   logic               dec_reti;
   logic               flag_z;
   logic               flag_c;
   logic [NUM_IRQ-1:0] irq_pending;

   logic [7:0]         opcode;
   logic [STEP_W-1:0]  step;
   logic               cb_mode;
   logic               int_mode;
   logic [7:0]         int_vec;
   logic [NUM_IRQ-1:0] int_ack;
   logic               ime;
   logic               halted;
   logic               seq_err;

   // CPU side: drives decoder/flag/irq information, observes sequencer state
   modport master (
      output db_in, dec_done, dec_is_cond, dec_next_cond, dec_halt,
             dec_ei, dec_di, dec_reti, flag_z, flag_c, irq_pending,
      input  opcode, step, cb_mode, int_mode, int_vec, int_ack,
             ime, halted, seq_err
   );

   // Sequencer side
   modport slave (
      input  db_in, dec_done, dec_is_cond, dec_next_cond, dec_halt,
             dec_ei, dec_di, dec_reti, flag_z, flag_c, irq_pending,
      output opcode, step, cb_mode, int_mode, int_vec, int_ack,
             ime, halted, seq_err
   );
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module irq_prio_enc #(
   parameter int NUM_IRQ = 5,
   parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic [NUM_IRQ-1:0] req,
   output logic               valid,
   output logic [IDX_W-1:0]   idx,
   output logic [NUM_IRQ-1:0] onehot
);

   // A request is granted only when no lower-indexed request is active
   genvar gi;
   generate
      for (gi = 0; gi < NUM_IRQ; gi++) begin : g_grant
         localparam logic [NUM_IRQ-1:0] BELOW = NUM_IRQ'((64'd1 << gi) - 64'd1);
         assign onehot[gi] = req[gi] & ~|(req & BELOW);
      end
   endgenerate

   assign valid = |req;

   // Binary index of the single granted bit
   always_comb begin
      idx = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (onehot[i]) idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// Sequential control core: IR, step counter, CB prefix, HALT, IME and
// interrupt dispatch, driven by the microcode decoder's done/cond outputs.
module control_sequencer
   import cpu_pkg::*;
#(
   parameter int          STEP_W     = 3,
   parameter int          NUM_IRQ    = 5,
   parameter logic [7:0]  VEC_BASE   = 8'h40,
   parameter int          VEC_STRIDE = 8
) (
   input logic          clk,
   input logic          rst,
   control_sequencer_if.slave bus
);

   localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   seq_state_t         state_reg,    state_next;
   opcode_t            opcode_reg,   opcode_next;
   logic [STEP_W-1:0]  step_reg,     step_next;
   logic [7:0]         int_vec_reg,  int_vec_next;
   logic [NUM_IRQ-1:0] int_ack_reg,  int_ack_next;
   logic               ime_reg,      ime_next;
   logic               ei_delay_reg, ei_delay_next;
   logic               seq_err_reg,  seq_err_next;

   logic               irq_valid;
   logic [IDX_W-1:0]   irq_idx;
   logic [NUM_IRQ-1:0] irq_onehot;

   cc_t                cc;
   logic               cond_true;
   logic               cond_eval;
   logic               ime_eff;
   logic               cb_prefix;
   logic               take_irq;

   irq_prio_enc #(
      .NUM_IRQ (NUM_IRQ),
      .IDX_W   (IDX_W)
   ) u_prio (
      .req     (bus.irq_pending),
      .valid   (irq_valid),
      .idx     (irq_idx),
      .onehot  (irq_onehot)
   );

   assign cc        = cc_t'(opcode_reg[4:3]);
   assign cond_eval = bus.dec_is_cond && (state_reg == ST_EXEC);
   // A bare CB in normal execution is a prefix and must not be split from its operand
   assign cb_prefix = (state_reg == ST_EXEC) && (opcode_reg == OPC_CB);

   // Branch condition from the flags
   always_comb begin
      cond_true = 1'b1;
      unique case (cc)
         CC_NZ: cond_true = ~bus.flag_z;
         CC_Z:  cond_true =  bus.flag_z;
         CC_NC: cond_true = ~bus.flag_c;
         CC_C:  cond_true =  bus.flag_c;
         default: cond_true = 1'b1;
      endcase
   end

   // Next-state: halt wake-up, instruction completion, branch skip, stepping
   always_comb begin
      state_next    = state_reg;
      opcode_next   = opcode_reg;
      step_next     = step_reg;
      int_vec_next  = int_vec_reg;
      int_ack_next  = '0;
      ime_next      = ime_reg;
      ei_delay_next = ei_delay_reg;
      seq_err_next  = seq_err_reg;
      ime_eff       = ime_reg;
      take_irq      = 1'b0;

      if (state_reg == ST_HALT) begin
         // Any pending source wakes the core; only IME decides whether to dispatch
         if (irq_valid) begin
            if (ime_reg) begin
               take_irq = 1'b1;
            end else begin
               state_next = ST_EXEC;
               step_next  = '0;
            end
         end
      end else if (bus.dec_done) begin
         step_next   = '0;
         opcode_next = bus.db_in;
         // DI clears before the check, RETI enables in time for it, EI waits one instruction
         ime_eff = (ime_reg & ~bus.dec_di) | bus.dec_reti;
         if (bus.dec_di) begin
            ime_next      = 1'b0;
            ei_delay_next = 1'b0;
         end else begin
            if (bus.dec_reti || ei_delay_reg) ime_next = 1'b1;
            ei_delay_next = bus.dec_ei;
         end

         if (ime_eff && irq_valid && !cb_prefix) begin
            take_irq = 1'b1;
         end else if (bus.dec_halt) begin
            state_next = ST_HALT;
         end else if (cb_prefix) begin
            state_next = ST_EXEC_CB;
         end else begin
            state_next = ST_EXEC;
         end
      end else if (cond_eval && !cond_true) begin
         step_next = bus.dec_next_cond;
      end else if (&step_reg) begin
         seq_err_next = 1'b1;
      end else begin
         step_next = step_reg + STEP_W'(1);
      end

      if (take_irq) begin
         state_next    = ST_INT;
         ime_next      = 1'b0;
         ei_delay_next = 1'b0;
         int_vec_next  = irq_vector(VEC_BASE, int'(irq_idx), VEC_STRIDE);
         int_ack_next  = irq_onehot;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_EXEC;
         opcode_reg   <= 8'h00;
         step_reg     <= '0;
         int_vec_reg  <= 8'h00;
         int_ack_reg  <= '0;
         ime_reg      <= 1'b0;
         ei_delay_reg <= 1'b0;
         seq_err_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         opcode_reg   <= opcode_next;
         step_reg     <= step_next;
         int_vec_reg  <= int_vec_next;
         int_ack_reg  <= int_ack_next;
         ime_reg      <= ime_next;
         ei_delay_reg <= ei_delay_next;
         seq_err_reg  <= seq_err_next;
      end
   end

   assign bus.opcode   = opcode_reg;
   assign bus.step     = step_reg;
   assign bus.cb_mode  = (state_reg == ST_EXEC_CB);
   assign bus.int_mode = (state_reg == ST_INT);
   assign bus.halted   = (state_reg == ST_HALT);
   assign bus.int_vec  = int_vec_reg;
   assign bus.int_ack  = int_ack_reg;
   assign bus.ime      = ime_reg;
   assign bus.seq_err  = seq_err_reg;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: expectations are queued with each
// stimulus cycle and compared after the following clock edge.
module tb_control_sequencer;

   localparam int STEP_W  = 3;
   localparam int NUM_IRQ = 5;

   localparam int F_OP   = 0;
   localparam int F_STEP = 1;
   localparam int F_CB   = 2;
   localparam int F_INT  = 3;
   localparam int F_VEC  = 4;
   localparam int F_ACK  = 5;
   localparam int F_IME  = 6;
   localparam int F_HALT = 7;
   localparam int F_ERR  = 8;

   typedef struct {
      string       tag;
      int          field;
      logic [31:0] value;
   } exp_t;

   logic clk;
   logic rst;
   int   check_count = 0;
   int   error_count = 0;
   int   cyc = 0;
   exp_t sb_q[$];

   control_sequencer_if #(.STEP_W(STEP_W), .NUM_IRQ(NUM_IRQ)) seq_bus ();

   control_sequencer #(
      .STEP_W     (STEP_W),
      .NUM_IRQ    (NUM_IRQ),
      .VEC_BASE   (8'h40),
      .VEC_STRIDE (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (seq_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_result(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_count++;
      if (obs !== exp) begin
         error_count++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] observed(input int f);
      case (f)
         F_OP:    return 32'(seq_bus.opcode);
         F_STEP:  return 32'(seq_bus.step);
         F_CB:    return 32'(seq_bus.cb_mode);
         F_INT:   return 32'(seq_bus.int_mode);
         F_VEC:   return 32'(seq_bus.int_vec);
         F_ACK:   return 32'(seq_bus.int_ack);
         F_IME:   return 32'(seq_bus.ime);
         F_HALT:  return 32'(seq_bus.halted);
         F_ERR:   return 32'(seq_bus.seq_err);
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic ex(input string tag, input int f, input logic [31:0] v);
      exp_t e;
      e.tag   = tag;
      e.field = f;
      e.value = v;
      sb_q.push_back(e);
   endtask

   task automatic expect_reset(input string pfx);
      ex({pfx, "_op"},   F_OP,   8'h00);
      ex({pfx, "_step"}, F_STEP, 0);
      ex({pfx, "_cb"},   F_CB,   0);
      ex({pfx, "_int"},  F_INT,  0);
      ex({pfx, "_vec"},  F_VEC,  0);
      ex({pfx, "_ack"},  F_ACK,  0);
      ex({pfx, "_ime"},  F_IME,  0);
      ex({pfx, "_halt"}, F_HALT, 0);
      ex({pfx, "_err"},  F_ERR,  0);
   endtask

   task automatic drive(input logic done, input logic [7:0] db, input logic is_cond,
                        input logic [STEP_W-1:0] nc, input logic halt, input logic ei,
                        input logic di, input logic reti);
      seq_bus.dec_done      = done;
      seq_bus.db_in         = db;
      seq_bus.dec_is_cond   = is_cond;
      seq_bus.dec_next_cond = nc;
      seq_bus.dec_halt      = halt;
      seq_bus.dec_ei        = ei;
      seq_bus.dec_di        = di;
      seq_bus.dec_reti      = reti;
   endtask

   task automatic idle();
      drive(1'b0, 8'h00, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic done_op(input logic [7:0] db);
      drive(1'b1, db, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      $display("cyc %0d: op=%02h step=%0d cb=%0b int=%0b vec=%02h ack=%05b ime=%0b halt=%0b err=%0b",
               cyc, seq_bus.opcode, seq_bus.step, seq_bus.cb_mode, seq_bus.int_mode,
               seq_bus.int_vec, seq_bus.int_ack, seq_bus.ime, seq_bus.halted, seq_bus.seq_err);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_result(e.tag, observed(e.field), e.value);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      seq_bus.flag_z      = 1'b0;
      seq_bus.flag_c      = 1'b0;
      seq_bus.irq_pending = '0;
      tick();
      expect_reset("rst0");
      tick();
      rst = 1'b0;

      // Conditional branches: JR NZ fails, JR Z taken, JR C fails, done beats failed cond
      done_op(8'h20);                  ex("ld20_op", F_OP, 8'h20); ex("ld20_step", F_STEP, 0); tick();
      seq_bus.flag_z = 1'b1;
      drive(1'b0, 8'h00, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0); ex("jrnz_fail_step", F_STEP, 3); tick();
      idle();                          ex("jrnz_inc_step", F_STEP, 4); tick();
      done_op(8'h28);                  ex("jrnz_done_step", F_STEP, 0); ex("jrnz_done_op", F_OP, 8'h28); tick();
      drive(1'b0, 8'h00, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0); ex("jrz_true_step", F_STEP, 1); tick();
      done_op(8'h38);                  ex("ld38_op", F_OP, 8'h38); tick();
      drive(1'b0, 8'h00, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0); ex("jrc_fail_step", F_STEP, 6); tick();
      drive(1'b1, 8'h00, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      ex("done_wins_step", F_STEP, 0); ex("done_wins_op", F_OP, 8'h00); tick();
      seq_bus.flag_z = 1'b0;

      // CB prefix handling
      done_op(8'hCB);                  ex("cb_pre_op", F_OP, 8'hCB); ex("cb_pre_cb", F_CB, 0); tick();
      done_op(8'h37);                  ex("cb_op", F_OP, 8'h37); ex("cb_mode_on", F_CB, 1); tick();
      seq_bus.flag_c = 1'b1;
      drive(1'b0, 8'h00, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0); ex("cb_nocond_step", F_STEP, 1); ex("cb_hold", F_CB, 1); tick();
      done_op(8'hCB);                  ex("cbcb_op", F_OP, 8'hCB); ex("cbcb_nochain", F_CB, 0); tick();
      done_op(8'h00);                  ex("cbcb_prefix_again", F_CB, 1); tick();
      done_op(8'h00);                  ex("cb_mode_off", F_CB, 0); tick();
      seq_bus.flag_c = 1'b0;

      // RETI enables, then dispatch with priority to lowest index
      drive(1'b1, 8'h00, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1); ex("reti_ime", F_IME, 1); ex("reti_noint", F_INT, 0); tick();
      seq_bus.irq_pending = 5'b10100;
      done_op(8'h12);
      ex("disp2_int", F_INT, 1); ex("disp2_vec", F_VEC, 8'h50); ex("disp2_ack", F_ACK, 5'b00100);
      ex("disp2_ime", F_IME, 0); ex("disp2_op", F_OP, 8'h12); ex("disp2_step", F_STEP, 0); tick();
      idle();                          ex("ack_pulse_end", F_ACK, 0); ex("int_hold", F_INT, 1); ex("int_step", F_STEP, 1); tick();
      done_op(8'h00);                  ex("int_exit", F_INT, 0); ex("int_exit_ack", F_ACK, 0); ex("int_exit_step", F_STEP, 0); tick();
      seq_bus.irq_pending = '0;

      // A pending interrupt must not split CB from its operand
      drive(1'b1, 8'hCB, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1); ex("reti2_ime", F_IME, 1); tick();
      seq_bus.irq_pending = 5'b00010;
      done_op(8'h11);                  ex("cbblk_int", F_INT, 0); ex("cbblk_cb", F_CB, 1); ex("cbblk_ime", F_IME, 1); tick();
      done_op(8'h00);
      ex("disp1_int", F_INT, 1); ex("disp1_vec", F_VEC, 8'h48); ex("disp1_ack", F_ACK, 5'b00010);
      ex("disp1_cb", F_CB, 0); ex("disp1_ime", F_IME, 0); tick();
      seq_bus.irq_pending = '0;
      done_op(8'h00);                  ex("disp1_exit", F_INT, 0); tick();

      // DI clears IME before the interrupt check
      drive(1'b1, 8'h00, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1); ex("reti3_ime", F_IME, 1); tick();
      seq_bus.irq_pending = 5'b00001;
      drive(1'b1, 8'h00, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0); ex("di_noint", F_INT, 0); ex("di_ime", F_IME, 0); tick();

      // EI takes effect after the next instruction's done
      drive(1'b1, 8'h00, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0); ex("ei_ime0", F_IME, 0); ex("ei_noint", F_INT, 0); tick();
      idle();                          ex("ei_next_step", F_STEP, 1); ex("ei_next_noint", F_INT, 0); tick();
      done_op(8'h00);                  ex("ei_late_noint", F_INT, 0); ex("ei_late_ime", F_IME, 1); tick();
      done_op(8'h00);
      ex("ei_disp_int", F_INT, 1); ex("ei_disp_vec", F_VEC, 8'h40); ex("ei_disp_ack", F_ACK, 5'b00001); ex("ei_disp_ime", F_IME, 0); tick();
      seq_bus.irq_pending = '0;
      done_op(8'h00);                  ex("ei_disp_exit", F_INT, 0); tick();

      // HALT with IME=0: wake without dispatch
      drive(1'b1, 8'h3C, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0); ex("halt_on", F_HALT, 1); ex("halt_op", F_OP, 8'h3C); ex("halt_step", F_STEP, 0); tick();
      drive(1'b0, 8'h00, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0); ex("halt_hold", F_HALT, 1); ex("halt_frz_step", F_STEP, 0); ex("halt_frz_op", F_OP, 8'h3C); tick();
      idle();
      seq_bus.irq_pending = 5'b00001;
      ex("wake_halt", F_HALT, 0); ex("wake_ack", F_ACK, 0); ex("wake_int", F_INT, 0); ex("wake_step", F_STEP, 0); ex("wake_op", F_OP, 8'h3C); tick();
      seq_bus.irq_pending = '0;

      // HALT with IME=1: wake and dispatch
      drive(1'b1, 8'h00, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1); ex("reti4_ime", F_IME, 1); tick();
      drive(1'b1, 8'h3C, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0); ex("halt2_on", F_HALT, 1); ex("halt2_ime", F_IME, 1); tick();
      idle();                          ex("halt2_hold", F_HALT, 1); tick();
      seq_bus.irq_pending = 5'b00001;
      ex("hdisp_halt", F_HALT, 0); ex("hdisp_int", F_INT, 1); ex("hdisp_vec", F_VEC, 8'h40);
      ex("hdisp_ack", F_ACK, 5'b00001); ex("hdisp_ime", F_IME, 0); ex("hdisp_op", F_OP, 8'h3C); tick();
      seq_bus.irq_pending = '0;
      done_op(8'h00);                  ex("hdisp_exit", F_INT, 0); ex("hdisp_ack_end", F_ACK, 0); tick();

      // Step overflow is sticky until reset
      idle();
      for (int i = 1; i <= 7; i++) begin
         ex($sformatf("ovf_step%0d", i), F_STEP, i);
         ex($sformatf("ovf_err%0d", i), F_ERR, 0);
         tick();
      end
      ex("ovf_hold_step", F_STEP, 7); ex("ovf_err_set", F_ERR, 1); tick();
      ex("ovf_hold_step2", F_STEP, 7); ex("ovf_err_sticky", F_ERR, 1); tick();
      rst = 1'b1;
      expect_reset("rst1");
      tick();
      rst = 1'b0;
      ex("post_rst_step", F_STEP, 1); ex("post_rst_err", F_ERR, 0); tick();

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
